// File: rtl/aes_pkg.sv
// Shared AES definitions: key-length encodings, GF(2^8) constants,
// key-schedule state encoding and small word helpers.
package aes_pkg;

    localparam int AES_KEY_BITS_128 = 128;
    localparam int AES_KEY_BITS_192 = 192;
    localparam int AES_KEY_BITS_256 = 256;

    localparam logic [7:0] RCON_INIT = 8'h01;
    localparam logic [7:0] GF_POLY   = 8'h1b;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_EXPAND = 2'd2,
        ST_DONE   = 2'd3
    } ks_state_t;

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? GF_POLY : 8'h00);
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES byte S-box; the table holds entry 0x00 in its top byte.
module aes_sbox (
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);

    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    logic [10:0] base_s;

    // Entry idx sits (255-idx) bytes above bit 0, and 255-idx is ~idx.
    assign base_s   = {~in_byte, 3'b000};
    assign out_byte = SBOX_TABLE[base_s +: 8];

endmodule

// File: rtl/aes_sub_word.sv
// 32-bit SubWord: four parallel byte S-boxes, shared with the cipher datapath.
module aes_sub_word (
    input  logic [31:0] din,
    output logic [31:0] dout
);

    for (genvar g = 0; g < 4; g++) begin : g_sbox
        aes_sbox u_sbox (
            .in_byte  (din[8*g +: 8]),
            .out_byte (dout[8*g +: 8])
        );
    end

endmodule

// File: rtl/aes_key_schedule_ctrl.sv
// Word-serial AES-128/192/256 key schedule: byte-wise key load, one expanded
// word per cycle into a flat buffer, registered indexed round-key read port.
module aes_key_schedule_ctrl
    import aes_pkg::*;
#(
    parameter int KEY_BITS = 128
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         key_valid,
    input  logic [7:0]   key_byte,
    output logic         key_ready,
    output logic         busy,
    output logic         done,
    input  logic [3:0]   rk_rd_idx,
    output logic [127:0] rk_rd_data,
    output logic         rk_rd_valid
);

    localparam int NK = KEY_BITS / 32;
    localparam int NR = NK + 6;
    localparam int NW = 4 * (NR + 1);
    localparam logic [5:0] NK_W      = 6'(NK);
    localparam logic [5:0] LAST_WORD = 6'(NW - 1);
    localparam logic [4:0] LAST_BYTE = 5'(4 * NK - 1);
    localparam logic [2:0] NK_M1     = 3'(NK - 1);
    localparam logic [3:0] NR_W      = 4'(NR);

    if (KEY_BITS != AES_KEY_BITS_128 && KEY_BITS != AES_KEY_BITS_192 &&
        KEY_BITS != AES_KEY_BITS_256) begin : g_bad_key_bits
        $error("aes_key_schedule_ctrl: KEY_BITS must be 128, 192 or 256");
    end

    ks_state_t      state_r, state_nxt_s;
    logic [4:0]     byte_cnt_r;
    logic [5:0]     word_idx_r;
    logic [2:0]     word_mod_r;
    logic [7:0]     rcon_r;
    logic           key_ready_r, busy_r, done_r;
    logic           rd_valid_r;
    logic [127:0]   rd_data_r;
    logic [31:0]    w_r [NW];

    logic           xfer_s, last_byte_s, done_nxt_s;
    logic [31:0]    prev_word_s, sub_in_s, sub_out_s, temp_s, new_word_s;

    assign xfer_s      = key_valid && key_ready_r;
    assign last_byte_s = (byte_cnt_r == LAST_BYTE);
    assign done_nxt_s  = (state_r == ST_DONE) && (state_nxt_s == ST_DONE);

    // Next-state decode for the load/expand sequencer.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE:   state_nxt_s = xfer_s ? ST_LOAD : ST_IDLE;
            ST_LOAD:   state_nxt_s = (xfer_s && last_byte_s) ? ST_EXPAND : ST_LOAD;
            ST_EXPAND: state_nxt_s = (word_idx_r == LAST_WORD) ? ST_DONE : ST_EXPAND;
            ST_DONE:   state_nxt_s = xfer_s ? ST_LOAD : ST_DONE;
            default:   state_nxt_s = ST_IDLE;
        endcase
    end

    // Expansion step: temp from w[i-1], then w[i] = w[i-NK] ^ temp.
    always_comb begin
        prev_word_s = w_r[word_idx_r - 6'd1];
        sub_in_s    = (word_mod_r == 3'd0) ? rot_word(prev_word_s) : prev_word_s;
        if (word_mod_r == 3'd0) begin
            temp_s = sub_out_s ^ {rcon_r, 24'h000000};
        end else if (NK == 8 && word_mod_r == 3'd4) begin
            temp_s = sub_out_s;
        end else begin
            temp_s = prev_word_s;
        end
        new_word_s = w_r[word_idx_r - NK_W] ^ temp_s;
    end

    aes_sub_word u_sub_word (
        .din  (sub_in_s),
        .dout (sub_out_s)
    );

    // Sequencer state, counters, rcon and status flags.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r     <= ST_IDLE;
            byte_cnt_r  <= 5'd0;
            word_idx_r  <= 6'd0;
            word_mod_r  <= 3'd0;
            rcon_r      <= RCON_INIT;
            key_ready_r <= 1'b1;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            key_ready_r <= (state_nxt_s != ST_EXPAND);
            // busy stays up through the first DONE cycle so it hands over to done
            busy_r      <= (state_nxt_s != ST_IDLE) && !done_nxt_s;
            done_r      <= done_nxt_s;
            if (xfer_s) begin
                byte_cnt_r <= last_byte_s ? 5'd0 : byte_cnt_r + 5'd1;
            end
            if (state_r == ST_EXPAND) begin
                word_idx_r <= word_idx_r + 6'd1;
                word_mod_r <= (word_mod_r == NK_M1) ? 3'd0 : word_mod_r + 3'd1;
                if (word_mod_r == 3'd0) begin
                    rcon_r <= xtime(rcon_r);
                end
            end else if (xfer_s && last_byte_s) begin
                word_idx_r <= NK_W;
                word_mod_r <= 3'd0;
                rcon_r     <= RCON_INIT;
            end
        end
    end

    // Word buffer: big-endian key bytes during load, expanded words after.
    always_ff @(posedge clk) begin
        if (rst && xfer_s) begin
            w_r[{3'b000, byte_cnt_r[4:2]}][{~byte_cnt_r[1:0], 3'b000} +: 8] <= key_byte;
        end else if (rst && state_r == ST_EXPAND) begin
            w_r[word_idx_r] <= new_word_s;
        end
    end

    // Registered round-key read port.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_valid_r <= 1'b0;
            rd_data_r  <= 128'h0;
        end else if (done_r && rk_rd_idx <= NR_W) begin
            rd_valid_r <= 1'b1;
            rd_data_r  <= {w_r[{rk_rd_idx, 2'b00}], w_r[{rk_rd_idx, 2'b01}],
                           w_r[{rk_rd_idx, 2'b10}], w_r[{rk_rd_idx, 2'b11}]};
        end else begin
            rd_valid_r <= 1'b0;
            rd_data_r  <= 128'h0;
        end
    end

    assign key_ready   = key_ready_r;
    assign busy        = busy_r;
    assign done        = done_r;
    assign rk_rd_valid = rd_valid_r;
    assign rk_rd_data  = rd_data_r;

endmodule

// File: tb/tb_aes_key_schedule_ctrl.sv
// Bench for aes_key_schedule_ctrl: one instance per key length, FIPS-197
// round-key vectors, handshake/latency corner sequences and a read scoreboard.
module tb_aes_key_schedule_ctrl;

    logic         clk;
    logic         rst;
    logic         kv    [3];
    logic [7:0]   kb    [3];
    logic         kr    [3];
    logic         bsy   [3];
    logic         dn    [3];
    logic [3:0]   idx   [3];
    logic [127:0] rdata [3];
    logic         rvld  [3];

    int total = 0;
    int bad   = 0;

    typedef struct {
        int           scen;
        int           n;
        logic [3:0]   idx;
        logic         valid;
        logic [127:0] data;
    } rd_vec_t;

    rd_vec_t tbl [18];
    rd_vec_t sb_q [$];

    localparam logic [127:0] KEY_A   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] KEY_B   = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [191:0] KEY_192 = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
    localparam logic [255:0] KEY_256 =
        256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    aes_key_schedule_ctrl #(.KEY_BITS(128)) u_dut128 (
        .clk(clk), .rst(rst), .key_valid(kv[0]), .key_byte(kb[0]), .key_ready(kr[0]),
        .busy(bsy[0]), .done(dn[0]), .rk_rd_idx(idx[0]), .rk_rd_data(rdata[0]),
        .rk_rd_valid(rvld[0])
    );
    aes_key_schedule_ctrl #(.KEY_BITS(192)) u_dut192 (
        .clk(clk), .rst(rst), .key_valid(kv[1]), .key_byte(kb[1]), .key_ready(kr[1]),
        .busy(bsy[1]), .done(dn[1]), .rk_rd_idx(idx[1]), .rk_rd_data(rdata[1]),
        .rk_rd_valid(rvld[1])
    );
    aes_key_schedule_ctrl #(.KEY_BITS(256)) u_dut256 (
        .clk(clk), .rst(rst), .key_valid(kv[2]), .key_byte(kb[2]), .key_ready(kr[2]),
        .busy(bsy[2]), .done(dn[2]), .rk_rd_idx(idx[2]), .rk_rd_data(rdata[2]),
        .rk_rd_valid(rvld[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Streams nbytes of a left-aligned key; optional 3-cycle stall after byte stall_after.
    task automatic load_key(input int n, input logic [255:0] key, input int nbytes,
                            input int stall_after, input bit from_done,
                            input int exp_total, input int exp_wait);
        int  cyc;
        int  s;
        bit  ready_seen;
        cyc = 0;
        idx[n] = 4'd0;
        if (from_done) chk($sformatf("done_before_reload[%0d]", n), 128'(dn[n]), 128'd1);
        for (int b = 0; b < nbytes; b++) begin
            kv[n] = 1'b1;
            kb[n] = key[255 - 8*b -: 8];
            chk($sformatf("key_ready_load[%0d] b%0d", n, b), 128'(kr[n]), 128'd1);
            step();
            cyc++;
            if (b == 0) begin
                chk($sformatf("busy_after_first[%0d]", n), 128'(bsy[n]), 128'd1);
                if (from_done) chk($sformatf("done_drop[%0d]", n), 128'(dn[n]), 128'd0);
            end
            if (b == stall_after) begin
                kv[n] = 1'b0;
                repeat (3) begin
                    step();
                    cyc++;
                end
            end
        end
        kv[n] = 1'b0;
        s = 0;
        ready_seen = 1'b0;
        while (dn[n] !== 1'b1 && s < 200) begin
            if (s < exp_wait - 1 && kr[n] !== 1'b0) ready_seen = 1'b1;
            if (s == 5) begin
                chk($sformatf("busy_read_valid[%0d]", n), 128'(rvld[n]), 128'd0);
                chk($sformatf("busy_read_data[%0d]", n), rdata[n], 128'h0);
            end
            step();
            s++;
            cyc++;
        end
        chk($sformatf("cycles_last_byte_to_done[%0d]", n), 128'(s), 128'(exp_wait));
        chk($sformatf("cycles_first_byte_to_done[%0d]", n), 128'(cyc), 128'(exp_total));
        chk($sformatf("key_ready_low_in_expand[%0d]", n), 128'(ready_seen), 128'd0);
        chk($sformatf("busy_low_at_done[%0d]", n), 128'(bsy[n]), 128'd0);
    endtask

    // Drive a read index, push the expectation, pop and compare one cycle later.
    task automatic rd_check(input int n, input logic [3:0] ri, input logic v, input logic [127:0] d);
        rd_vec_t e;
        idx[n] = ri;
        sb_q.push_back('{scen: 0, n: n, idx: ri, valid: v, data: d});
        step();
        e = sb_q.pop_front();
        chk($sformatf("rd_valid[%0d] idx%0d", e.n, e.idx), 128'(rvld[e.n]), 128'(e.valid));
        chk($sformatf("rd_data[%0d] idx%0d", e.n, e.idx), rdata[e.n], e.data);
    endtask

    task automatic apply_table(input int scen);
        for (int k = 0; k < 18; k++) begin
            if (tbl[k].scen == scen) rd_check(tbl[k].n, tbl[k].idx, tbl[k].valid, tbl[k].data);
        end
    endtask

    initial begin
        int  s;
        bit  done_seen;

        tbl[0]  = '{1, 0, 4'd0,  1'b1, KEY_A};
        tbl[1]  = '{1, 0, 4'd1,  1'b1, 128'ha0fafe1788542cb123a339392a6c7605};
        tbl[2]  = '{1, 0, 4'd2,  1'b1, 128'hf2c295f27a96b9435935807a7359f67f};
        tbl[3]  = '{1, 0, 4'd10, 1'b1, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
        tbl[4]  = '{1, 0, 4'd11, 1'b0, 128'h0};
        tbl[5]  = '{1, 0, 4'd15, 1'b0, 128'h0};
        tbl[6]  = '{4, 0, 4'd1,  1'b1, 128'ha0fafe1788542cb123a339392a6c7605};
        tbl[7]  = '{4, 0, 4'd10, 1'b1, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
        tbl[8]  = '{5, 0, 4'd0,  1'b1, KEY_B};
        tbl[9]  = '{5, 0, 4'd1,  1'b1, 128'hd6aa74fdd2af72fadaa678f1d6ab76fe};
        tbl[10] = '{5, 0, 4'd10, 1'b1, 128'h13111d7fe3944a17f307a78b4d2b30c5};
        tbl[11] = '{2, 1, 4'd0,  1'b1, 128'h8e73b0f7da0e6452c810f32b809079e5};
        tbl[12] = '{2, 1, 4'd12, 1'b1, 128'he98ba06f448c773c8ecc720401002202};
        tbl[13] = '{2, 1, 4'd13, 1'b0, 128'h0};
        tbl[14] = '{3, 2, 4'd0,  1'b1, 128'h603deb1015ca71be2b73aef0857d7781};
        tbl[15] = '{3, 2, 4'd1,  1'b1, 128'h1f352c073b6108d72d9810a30914dff4};
        tbl[16] = '{3, 2, 4'd14, 1'b1, 128'hfe4890d1e6188d0b046df344706c631e};
        tbl[17] = '{3, 2, 4'd15, 1'b0, 128'h0};

        rst = 1'b0;
        for (int n = 0; n < 3; n++) begin
            kv[n]  = 1'b0;
            kb[n]  = 8'h00;
            idx[n] = 4'd0;
        end
        repeat (3) step();
        for (int n = 0; n < 3; n++) begin
            chk($sformatf("reset_key_ready[%0d]", n), 128'(kr[n]), 128'd1);
            chk($sformatf("reset_busy[%0d]", n), 128'(bsy[n]), 128'd0);
            chk($sformatf("reset_done[%0d]", n), 128'(dn[n]), 128'd0);
            chk($sformatf("reset_rd_valid[%0d]", n), 128'(rvld[n]), 128'd0);
            chk($sformatf("reset_rd_data[%0d]", n), rdata[n], 128'h0);
        end
        rst = 1'b1;
        step();

        // AES-128, no stalls
        load_key(0, {KEY_A, 128'h0}, 16, -1, 1'b0, 57, 41);
        apply_table(1);

        // Reload, then reset while word 20 is being expanded
        for (int b = 0; b < 16; b++) begin
            kv[0] = 1'b1;
            kb[0] = KEY_A[127 - 8*b -: 8];
            step();
        end
        kv[0] = 1'b0;
        repeat (16) step();
        rst = 1'b0;
        step();
        chk("midexp_reset_key_ready", 128'(kr[0]), 128'd1);
        chk("midexp_reset_busy", 128'(bsy[0]), 128'd0);
        chk("midexp_reset_done", 128'(dn[0]), 128'd0);
        rst = 1'b1;
        done_seen = 1'b0;
        s = 0;
        repeat (60) begin
            if (dn[0] !== 1'b0) done_seen = 1'b1;
            step();
            s++;
        end
        chk("midexp_done_stays_low", 128'(done_seen), 128'd0);
        rd_check(0, 4'd0, 1'b0, 128'h0);
        load_key(0, {KEY_A, 128'h0}, 16, -1, 1'b0, 57, 41);
        apply_table(4);

        // Reload while DONE with a second key
        load_key(0, {KEY_B, 128'h0}, 16, -1, 1'b1, 57, 41);
        apply_table(5);

        // AES-192 with a 3-cycle stall after byte 5
        load_key(1, {KEY_192, 64'h0}, 24, 5, 1'b0, 74, 47);
        apply_table(2);

        // AES-256
        load_key(2, KEY_256, 32, -1, 1'b0, 85, 53);
        apply_table(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/aes_key_schedule_ctrl.md
Name: aes_key_schedule_ctrl

Overview:
Parametrised word-serial AES key-schedule controller supporting AES-128, AES-192 and AES-256.
- Accepts the cipher key one byte per cycle under a valid/ready handshake.
- Expands the key one 32-bit word per cycle and stores all round keys in an internal buffer.
- Serves round keys through an indexed read port to the round datapath.
- Adds behaviour the 128-bit-only controller lacked: selectable key length, flow-controlled load, done/busy status and random-access read-back.

Parameters:
- KEY_BITS, 128, cipher key length; legal values 128/192/256, any other value is an elaboration error.
- NK (localparam), KEY_BITS/32, key length in words (4/6/8).
- NR (localparam), NK+6, number of rounds (10/12/14).
- NW (localparam), 4*(NR+1), total schedule words (44/52/60).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-low.
- key_valid  in  1  key_byte holds a valid key byte.
- key_byte  in  8  key byte; the first byte is the MSB of w[0].
- key_ready  out  1  block can accept a key byte.
- busy  out  1  load or expansion in progress.
- done  out  1  schedule complete; round keys readable.
- rk_rd_idx  in  4  round-key index, 0..NR.
- rk_rd_data  out  128  round key {w[4r],w[4r+1],w[4r+2],w[4r+3]}, registered.
- rk_rd_valid  out  1  rk_rd_data is valid for the index sampled last cycle.

Behaviour:
- Reset (rst==0 at a clock edge):
  - State goes to IDLE; byte and word counters clear; rcon = 8'h01.
  - Outputs: key_ready=1, busy=0, done=0, rk_rd_valid=0, rk_rd_data=0.
  - The word buffer is not cleared.
  - Reset takes priority over every other event, including mid-LOAD and mid-EXPAND.
- Handshake: a byte is transferred on any edge where key_valid && key_ready.
  - key_ready=1 in IDLE, LOAD and DONE; key_ready=0 in EXPAND.
- IDLE: the first transfer writes byte 0 and moves to LOAD; busy=1 from the next cycle.
- DONE: a transfer starts a new key load. done drops the cycle after the transfer, and the byte is stored as byte 0.
- LOAD:
  - Bytes pack big-endian into w[0..NK-1].
  - If key_valid is low, the byte count holds (stall) with no timeout.
  - After byte 4*NK-1 is accepted, go to EXPAND with i=NK.
- EXPAND: one word per cycle for i = NK .. NW-1.
  - temp = w[i-1].
  - If i mod NK == 0: temp = SubWord(RotWord(temp)) ^ {rcon,24'h0}, then rcon <= xtime(rcon), where xtime(x) = {x[6:0],1'b0} ^ (x[7] ? 8'h1b : 8'h00).
  - Else if NK==8 and i mod NK == 4: temp = SubWord(temp).
  - w[i] = w[i-NK] ^ temp.
  - Expansion takes NW-NK cycles: 40, 46 or 52.
  - After w[NW-1] is written, go to DONE; done=1 and busy=0 on the following cycle.
- DONE: done holds until reset or a new key load.
- Read port:
  - Sampled every cycle; response appears next cycle (1-cycle latency).
  - rk_rd_valid = done && rk_rd_idx <= NR.
  - rk_rd_data = the selected round key when valid, else 128'h0.
  - Indices greater than NR, and any read while not done, return rk_rd_valid=0 with data 0.
- S-box: four parallel instances of the combinational byte S-box, FIPS-197 table.

Decomposition:
- Shared package aes_pkg:
  - Key-length encodings.
  - Rcon start value 8'h01 and reduction polynomial 8'h1b.
  - State encoding IDLE/LOAD/EXPAND/DONE.
  - xtime and RotWord functions.
- Sub-module aes_sub_word: 32-bit SubWord built from four aes_sbox byte instances, also reused by the cipher datapath.
- The word buffer is a flat register array inside this block.

Test Plan:
- KEY_BITS=128, key 2b7e151628aed2a6abf7158809cf4f3c streamed with no stalls:
  - done rises 16+40+1 cycles after the first byte.
  - idx1 -> a0fafe1788542cb123a339392a6c7605.
  - idx10 -> d014f9a8c9ee2589e13f0cc8b6630ca6.
- KEY_BITS=192, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, key_valid dropped for 3 cycles after byte 5:
  - idx12 -> e98ba06f448c773c8ecc720401002202.
  - Expansion still takes 46 cycles.
- KEY_BITS=256, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4:
  - idx14 -> fe4890d1e6188d0b046df344706c631e.
  - idx15 -> rk_rd_valid=0, data 0.
- Reset mid-EXPAND (rst=0 for 1 cycle at word 20), then reload of the same AES-128 key:
  - done stays 0 until the new expansion completes.
  - Final keys match scenario 1.
- Reload while DONE with key 000102030405060708090a0b0c0d0e0f:
  - done falls the cycle after the first byte; key_ready=0 throughout EXPAND.
  - idx10 -> 13111d7fe3944a17f307a78b4d2b30c5.
- Read while busy with idx 0 -> rk_rd_valid=0, rk_rd_data=0.
